// File: rtl/ad9958_spi_arbiter.sv
// rtl/ad9958_spi_arbiter.sv - round-robin arbiter with lock sharing one AD9958 SPI serializer
// Optional busy watchdog enabled by defining AD9958_ARB_WDT_EN.
module ad9958_spi_arbiter #(
   parameter int NUM_REQ       = 2,
   parameter int PACK_W        = 5,
   parameter int DATA_W        = 64,
   parameter int START_TIMEOUT = 4,
   parameter int WDT_CYCLES    = 4096
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*PACK_W-1:0] req_packs,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_accept,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [1:0]                grant_id,
   output logic                      grant_active,
   output logic                      spi_trigger,
   output logic [PACK_W-1:0]         spi_packs_to_send,
   output logic [DATA_W-1:0]         spi_data_input,
   input  logic                      spi_busy
`ifdef AD9958_ARB_WDT_EN
   ,
   output logic                      wdt_error
`endif
);

   localparam int ST_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_END, DONE} state_t;

   state_t              state, state_d;
   logic [1:0]          rr_ptr, rr_d;
   logic                lock_valid, lock_valid_d;
   logic [1:0]          lock_owner, lock_owner_d;
   logic [1:0]          grant_id_d;
   logic                grant_active_d;
   logic                trigger_d;
   logic [NUM_REQ-1:0]  accept_d, done_d;
   logic [PACK_W-1:0]   packs_d;
   logic [DATA_W-1:0]   data_d;
   logic [ST_W-1:0]     st_cnt, st_cnt_d;
   logic                zero_pend, zero_d;
   logic                go_done;

   logic [NUM_REQ-1:0]  owner_mask, grant_mask, eligible;
   logic                owner_lock, cur_lock, lock_hold;
   logic                found;
   logic [1:0]          win;
   logic [PACK_W-1:0]   win_packs;
   logic [DATA_W-1:0]   win_data;

`ifdef AD9958_ARB_WDT_EN
   localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   logic [WDT_W-1:0]    wdt_cnt, wdt_cnt_d;
   logic                wdt_error_d;
   logic                wdt_rel, wdt_rel_d;
`endif

   always_comb begin
      owner_mask = '0;
      grant_mask = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         owner_mask[j] = (j == int'(lock_owner));
         grant_mask[j] = (j == int'(grant_id));
      end
   end

   assign owner_lock = |(owner_mask & req_lock);
   assign cur_lock   = |(grant_mask & req_lock);
   // A held lock hides every other requester, even while the owner is not valid.
   assign lock_hold  = lock_valid && owner_lock;
   assign eligible   = lock_hold ? (req_valid & owner_mask) : req_valid;

   always_comb begin
      found     = 1'b0;
      win       = '0;
      win_packs = '0;
      win_data  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && (j == (int'(rr_ptr) + k) % NUM_REQ) && eligible[j]) begin
               found     = 1'b1;
               win       = 2'(j);
               win_packs = req_packs[j*PACK_W +: PACK_W];
               win_data  = req_data[j*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_comb begin
      state_d        = state;
      rr_d           = rr_ptr;
      lock_valid_d   = lock_valid;
      lock_owner_d   = lock_owner;
      grant_id_d     = grant_id;
      grant_active_d = grant_active;
      trigger_d      = 1'b0;
      accept_d       = '0;
      done_d         = '0;
      packs_d        = spi_packs_to_send;
      data_d         = spi_data_input;
      st_cnt_d       = st_cnt;
      zero_d         = zero_pend;
      go_done        = 1'b0;
`ifdef AD9958_ARB_WDT_EN
      wdt_cnt_d      = wdt_cnt;
      wdt_error_d    = wdt_error;
      wdt_rel_d      = wdt_rel;
`endif
      case (state)
         IDLE: begin
            if (lock_valid && !owner_lock) begin
               lock_valid_d = 1'b0;
            end
            if (found) begin
               state_d        = WAIT_START;
               grant_id_d     = win;
               grant_active_d = 1'b1;
               st_cnt_d       = '0;
               zero_d         = (win_packs == '0);
               for (int j = 0; j < NUM_REQ; j++) begin
                  accept_d[j] = (j == int'(win));
               end
               // Zero-length words are acknowledged without touching the serializer.
               if (win_packs != '0) begin
                  trigger_d = 1'b1;
                  packs_d   = win_packs;
                  data_d    = win_data;
               end
            end
         end
         WAIT_START: begin
            if (zero_pend) begin
               go_done = 1'b1;
            end else if (spi_busy) begin
               state_d = WAIT_END;
`ifdef AD9958_ARB_WDT_EN
               wdt_cnt_d = '0;
`endif
            end else if (st_cnt == ST_W'(START_TIMEOUT - 1)) begin
               go_done = 1'b1;
            end else begin
               st_cnt_d = st_cnt + 1'b1;
            end
         end
         WAIT_END: begin
            if (!spi_busy) begin
               go_done = 1'b1;
`ifdef AD9958_ARB_WDT_EN
            end else if (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
               go_done     = 1'b1;
               wdt_error_d = 1'b1;
               wdt_rel_d   = 1'b1;
            end else begin
               wdt_cnt_d = wdt_cnt + 1'b1;
`endif
            end
         end
         DONE: begin
            state_d      = IDLE;
            rr_d         = grant_id;
            lock_owner_d = grant_id;
`ifdef AD9958_ARB_WDT_EN
            lock_valid_d = cur_lock && !wdt_rel;
            wdt_rel_d    = 1'b0;
`else
            lock_valid_d = cur_lock;
`endif
         end
         default: state_d = IDLE;
      endcase
      if (go_done) begin
         state_d        = DONE;
         done_d         = grant_mask;
         grant_active_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state             <= IDLE;
         rr_ptr            <= '0;
         lock_valid        <= 1'b0;
         lock_owner        <= '0;
         grant_id          <= '0;
         grant_active      <= 1'b0;
         spi_trigger       <= 1'b0;
         req_accept        <= '0;
         req_done          <= '0;
         spi_packs_to_send <= '0;
         spi_data_input    <= '0;
         st_cnt            <= '0;
         zero_pend         <= 1'b0;
      end else begin
         state             <= state_d;
         rr_ptr            <= rr_d;
         lock_valid        <= lock_valid_d;
         lock_owner        <= lock_owner_d;
         grant_id          <= grant_id_d;
         grant_active      <= grant_active_d;
         spi_trigger       <= trigger_d;
         req_accept        <= accept_d;
         req_done          <= done_d;
         spi_packs_to_send <= packs_d;
         spi_data_input    <= data_d;
         st_cnt            <= st_cnt_d;
         zero_pend         <= zero_d;
      end
   end

`ifdef AD9958_ARB_WDT_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wdt_cnt   <= '0;
         wdt_error <= 1'b0;
         wdt_rel   <= 1'b0;
      end else begin
         wdt_cnt   <= wdt_cnt_d;
         wdt_error <= wdt_error_d;
         wdt_rel   <= wdt_rel_d;
      end
   end
`endif

endmodule

// File: tb/tb_ad9958_spi_arbiter.sv
// tb/tb_ad9958_spi_arbiter.sv - randomized self-checking bench for ad9958_spi_arbiter
// Watchdog steps are included when AD9958_ARB_WDT_EN is defined.
`timescale 1ns/1ps
module tb_ad9958_spi_arbiter;

   localparam int NUM_REQ       = 2;
   localparam int PACK_W        = 5;
   localparam int DATA_W        = 64;
   localparam int START_TIMEOUT = 4;
   localparam int WDT_CYCLES    = 16;
   localparam int QD            = 32;

   logic                      clock = 1'b0;
   logic                      reset_n;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ*PACK_W-1:0] req_packs;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_accept;
   logic [NUM_REQ-1:0]        req_done;
   logic [1:0]                grant_id;
   logic                      grant_active;
   logic                      spi_trigger;
   logic [PACK_W-1:0]         spi_packs_to_send;
   logic [DATA_W-1:0]         spi_data_input;
   logic                      spi_busy;
`ifdef AD9958_ARB_WDT_EN
   logic                      wdt_error;
`endif

   always #5 clock = ~clock;

   ad9958_spi_arbiter #(
      .NUM_REQ(NUM_REQ), .PACK_W(PACK_W), .DATA_W(DATA_W),
      .START_TIMEOUT(START_TIMEOUT), .WDT_CYCLES(WDT_CYCLES)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_lock(req_lock),
      .req_packs(req_packs), .req_data(req_data),
      .req_accept(req_accept), .req_done(req_done),
      .grant_id(grant_id), .grant_active(grant_active),
      .spi_trigger(spi_trigger), .spi_packs_to_send(spi_packs_to_send),
      .spi_data_input(spi_data_input), .spi_busy(spi_busy)
`ifdef AD9958_ARB_WDT_EN
      , .wdt_error(wdt_error)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Requester word queues and transaction-level arbitration model.
   logic [PACK_W-1:0] w_packs [NUM_REQ][QD];
   logic [DATA_W-1:0] w_data  [NUM_REQ][QD];
   logic              w_lock  [NUM_REQ][QD];
   int                head    [NUM_REQ];
   int                tail    [NUM_REQ];
   logic              cur_lock[NUM_REQ];
   int                m_rr;
   int                m_owner;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic push(input int i, input logic [PACK_W-1:0] p, input logic [DATA_W-1:0] d, input logic l);
      w_packs[i][tail[i]] = p;
      w_data[i][tail[i]]  = d;
      w_lock[i][tail[i]]  = l;
      tail[i]++;
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = (head[i] < tail[i]);
         req_lock[i]  = cur_lock[i];
         req_packs[i*PACK_W +: PACK_W] = (head[i] < tail[i]) ? w_packs[i][head[i]] : '0;
         req_data[i*DATA_W +: DATA_W]  = (head[i] < tail[i]) ? w_data[i][head[i]]  : '0;
      end
   endtask

   function automatic int model_pick();
      if (m_owner >= 0 && cur_lock[m_owner])
         return (head[m_owner] < tail[m_owner]) ? m_owner : -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (head[(m_rr + k) % NUM_REQ] < tail[(m_rr + k) % NUM_REQ])
            return (m_rr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_accept"}, req_accept, 0);
      check({tag, "_done"}, req_done, 0);
      check({tag, "_grant_id"}, grant_id, 0);
      check({tag, "_active"}, grant_active, 0);
      check({tag, "_trigger"}, spi_trigger, 0);
      check({tag, "_packs"}, spi_packs_to_send, 0);
      check({tag, "_data"}, spi_data_input, 0);
   endtask

   task automatic wait_accept(input int id, input logic [PACK_W-1:0] pk, input logic [DATA_W-1:0] dt);
      int n;
      n = 0;
      while (req_accept === '0 && n < 40) begin
         step();
         n++;
      end
      check("accept_wait", n < 40, 1);
      check("accept_id", req_accept, 64'(1) << id);
      check("grant_id", grant_id, id);
      check("grant_active", grant_active, 1);
      check("trigger", spi_trigger, pk != 0);
      if (pk != 0) begin
         check("spi_packs", spi_packs_to_send, pk);
         check("spi_data", spi_data_input, dt);
      end
   endtask

   // One full transfer: busy rises d cycles after trigger and stays high len cycles (len=0: never).
   task automatic xfer(input int d, input int len);
      int id, lat, exp_lat;
      logic [PACK_W-1:0] pk;
      logic [DATA_W-1:0] dt;
      logic extra;
      id = model_pick();
      if (id < 0) begin
         $display("FAIL model_pick: no eligible requester in directed sequence");
         $fatal(1);
      end
      pk = w_packs[id][head[id]];
      dt = w_data[id][head[id]];
      drive_reqs();
      wait_accept(id, pk, dt);
      cur_lock[id] = w_lock[id][head[id]];
      head[id]++;
      drive_reqs();
      if (pk == 0) exp_lat = 1;
      else if (len > 0 && d < START_TIMEOUT) exp_lat = d + len + 1;
      else exp_lat = START_TIMEOUT;
      lat = 0;
      extra = 1'b0;
      for (int k = 0; k < 80 && lat == 0; k++) begin
         spi_busy = (pk != 0) && (len > 0) && (k >= d) && (k < d + len);
         step();
         if (req_done !== '0) lat = k + 1;
         else if (spi_trigger !== 1'b0 || req_accept !== '0) extra = 1'b1;
      end
      spi_busy = 1'b0;
      check("done_latency", lat, exp_lat);
      check("done_id", req_done, 64'(1) << id);
      check("done_active", grant_active, 0);
      check("no_extra_pulse", extra, 0);
      m_rr    = id;
      m_owner = cur_lock[id] ? id : -1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, cnt, lat;
      reset_n   = 1'b0;
      req_valid = '0;
      req_lock  = '0;
      req_packs = '0;
      req_data  = '0;
      spi_busy  = 1'b0;
      m_rr      = 0;
      m_owner   = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
         cur_lock[i] = 1'b0;
      end
      step();
      step();
      check_idle_outputs("reset");
      reset_n = 1'b1;
      step();

      // Single request from requester 0 with a 10-cycle busy.
      push(0, 5'd1, 64'h56, 1'b0);
      xfer(1, 10);

      // Contention with no locks: grants alternate starting at requester 1.
      for (int k = 0; k < 4; k++) begin
         push(0, 5'($urandom_range(1, 31)), {$urandom, $urandom}, 1'b0);
         push(1, 5'($urandom_range(1, 31)), {$urandom, $urandom}, 1'b0);
      end
      for (int k = 0; k < 8; k++) xfer($urandom_range(0, 3), $urandom_range(1, 8));

      // Locked three-word sequence from requester 1 while requester 0 waits.
      push(1, 5'd1, 64'h04, 1'b1);
      push(1, 5'd4, 64'h1999999A, 1'b1);
      push(1, 5'd1, 64'h06, 1'b0);
      push(0, 5'd2, {$urandom, $urandom}, 1'b0);
      for (int k = 0; k < 4; k++) xfer($urandom_range(0, 2), $urandom_range(1, 6));

      // Serializer never goes busy, then a zero-pack word.
      push(0, 5'd3, {$urandom, $urandom}, 1'b0);
      xfer(0, 0);
      push(1, 5'd0, {$urandom, $urandom}, 1'b0);
      xfer(0, 5);

      // Random batches; the last word in each queue drops its lock.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt = $urandom_range(1, 3);
            for (int k = 0; k < cnt; k++)
               push(i, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                    (k == cnt - 1) ? 1'b0 : 1'($urandom_range(0, 1)));
         end
         n = 0;
         while ((head[0] < tail[0] || head[1] < tail[1]) && n < 20) begin
            xfer($urandom_range(0, 3), $urandom_range(0, 9));
            n++;
         end
      end

      // Reset during WAIT_END while requester 1 owns the lock.
      push(1, 5'd2, {$urandom, $urandom}, 1'b1);
      push(1, 5'd2, {$urandom, $urandom}, 1'b1);
      xfer(0, 3);
      drive_reqs();
      wait_accept(1, w_packs[1][head[1]], w_data[1][head[1]]);
      cur_lock[1] = 1'b1;
      head[1]++;
      drive_reqs();
      spi_busy = 1'b1;
      step();
      step();
      step();
      check("midxfer_active", grant_active, 1);
      reset_n = 1'b0;
      step();
      check_idle_outputs("midreset");
      reset_n = 1'b1;
      step();
      step();
      check("postreset_idle", grant_active, 0);
      spi_busy = 1'b0;
      step();
      m_rr    = 0;
      m_owner = -1;
      push(0, 5'd7, {$urandom, $urandom}, 1'b0);
      xfer(1, 3);
      cur_lock[1] = 1'b0;

`ifdef AD9958_ARB_WDT_EN
      // Busy stuck high: watchdog forces done, sets a sticky error and releases the lock.
      push(0, 5'd2, {$urandom, $urandom}, 1'b1);
      drive_reqs();
      wait_accept(0, w_packs[0][head[0]], w_data[0][head[0]]);
      cur_lock[0] = 1'b1;
      head[0]++;
      drive_reqs();
      spi_busy = 1'b1;
      lat = 0;
      for (int k = 0; k < 200 && lat == 0; k++) begin
         step();
         if (req_done !== '0) lat = k + 1;
      end
      check("wdt_latency", lat, WDT_CYCLES + 1);
      check("wdt_error_set", wdt_error, 1);
      spi_busy = 1'b0;
      m_rr    = 0;
      m_owner = -1;
      push(0, 5'd1, {$urandom, $urandom}, 1'b0);
      push(1, 5'd1, {$urandom, $urandom}, 1'b0);
      xfer(0, 2);
      cur_lock[0] = 1'b0;
      xfer(0, 2);
      check("wdt_error_sticky", wdt_error, 1);
      reset_n = 1'b0;
      step();
      check("wdt_error_reset", wdt_error, 0);
      reset_n = 1'b1;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ad9958_spi_arbiter.md
Name: ad9958_spi_arbiter

Overview:
Shares the single AD9958 SPI serializer (trigger / packs_to_send / data_input / busy) between NUM_REQ requesters. Typical requesters are the DDS core, a host register-write path and a sweep engine. The block arbitrates round-robin and supports a lock so a multi-word sequence (instruction byte + register data) is never interleaved. It issues one serializer transfer per grant and reports per-requester accept and done pulses.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
PACK_W, 5, width of packs_to_send field
DATA_W, 64, width of data word
START_TIMEOUT, 4, cycles to wait for spi_busy to rise after trigger before treating the transfer as complete
WDT_CYCLES, 4096, busy watchdog limit (optional feature only)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_lock  in  NUM_REQ  keep grant after the current transfer
req_packs  in  NUM_REQ*PACK_W  packed pack counts; requester i at [i*PACK_W +: PACK_W]
req_data  in  NUM_REQ*DATA_W  packed data words; requester i at [i*DATA_W +: DATA_W]
req_accept  out  NUM_REQ  1-cycle pulse: word latched
req_done  out  NUM_REQ  1-cycle pulse: transfer complete
grant_id  out  2  index of current/last owner
grant_active  out  1  a transfer is in flight
spi_trigger  out  1  1-cycle start pulse to serializer
spi_packs_to_send  out  PACK_W  latched pack count
spi_data_input  out  DATA_W  latched data word
spi_busy  in  1  serializer busy
wdt_error  out  1  sticky watchdog flag (optional feature only)

Behaviour:
- Reset (sync, reset_n=0 at posedge): all outputs 0, state IDLE, rr_ptr=0, no lock owner. A transfer already in the serializer is not aborted.
- States: IDLE, WAIT_START, WAIT_END, DONE.
- IDLE, lock handling:
  - If a lock owner exists and its req_lock=0, release the lock in the same cycle and arbitrate normally.
  - If a lock owner exists and holds req_lock=1, only the owner may be granted. Others wait even if the owner's req_valid=0.
- IDLE, arbitration: round-robin search starting at rr_ptr+1 mod NUM_REQ. The first requester with req_valid=1 wins at cycle T.
- Cycle T+1 (registered outputs):
  - spi_trigger=1, req_accept[i]=1, grant_id=i, grant_active=1.
  - spi_packs_to_send and spi_data_input hold the values latched at T.
  - State goes to WAIT_START.
- Latched spi_packs_to_send and spi_data_input stay stable until the next trigger.
- Requesters must update or drop req_valid in the cycle after req_accept. req_valid low while not granted has no effect.
- Zero pack count (req_packs=0): accept at T+1 with no spi_trigger, then go directly to DONE.
- WAIT_START:
  - spi_busy=1 moves to WAIT_END.
  - If START_TIMEOUT cycles pass with spi_busy=0, go to DONE.
  - spi_busy already 1 at trigger is treated as busy risen.
- WAIT_END: spi_busy=0 moves to DONE.
- DONE (1 cycle):
  - req_done[i]=1 and grant_active=0. rr_ptr=i.
  - If req_lock[i]=1 in this cycle, i becomes lock owner; otherwise no owner.
  - Return to IDLE.
- Throughput: back-to-back transfers from one locked owner have a minimum trigger-to-trigger spacing of busy duration + 3 cycles.
- Only one of req_accept / req_done may be high per cycle, and only for grant_id.
- spi_trigger is never asserted while state≠IDLE→WAIT_START.

Optional Feature:
AD9958_ARB_WDT_EN:
- Defined: a counter runs in WAIT_END. If spi_busy stays 1 for WDT_CYCLES cycles, set wdt_error (sticky until reset), force DONE, pulse req_done and release any lock.
- Undefined: no wdt_error port; WAIT_END waits indefinitely.

Test Plan:
- Single request: requester 0 valid, packs=1, data=0x56 → trigger at T+1, spi_data_input=0x56, accept[0] at T+1; busy high 10 cycles → done[0] 1 cycle after busy falls.
- Contention: both requesters valid continuously, lock=0 → grants alternate 1,0,1,0 (rr_ptr starts 0).
- Lock: req 1 holds lock for 3 words (inst 0x04, then 4-byte FTW 0x1999999A, then inst 0x06) while req 0 valid → three consecutive grants to 1. Req 0 is granted only after req 1 drops lock.
- No busy: serializer never raises busy → done 4 cycles (START_TIMEOUT) after trigger; packs=0 → accept with no trigger, done next cycle.
- Reset mid-WAIT_END: reset_n low 1 cycle → all outputs 0, lock cleared, next request granted normally.
- With AD9958_ARB_WDT_EN and WDT_CYCLES=16: busy stuck high → wdt_error=1 and done pulse after 16 cycles; wdt_error stays 1 until reset.
